// File: rtl/npc_sim_mem_if.sv
// Request/response bus between an NPC bus adapter (master) and the simulation memory (slave).
interface npc_sim_mem_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W/8-1:0] req_wmask;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/npc_sim_mem.sv
// Self-contained simulation memory: one outstanding request, programmable read latency,
// byte-masked writes and an error response for addresses outside the mapped window.
module npc_sim_mem #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned       LATENCY   = 2
) (
    input logic           clk,
    input logic           reset,
    npc_sim_mem_if.slave  bus
);
    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(NBYTES);
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ready_q;
    logic              valid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              wen_q;
    logic [IDX_W-1:0]  idx_q;
    logic              inr_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] idx_full;
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              accept;

    // The subtraction wraps for addresses below the base; the explicit compare rejects those.
    assign off      = bus.req_addr - BASE_ADDR;
    assign idx_full = off >> OFF_W;
    assign idx      = idx_full[IDX_W-1:0];
    assign in_range = (bus.req_addr >= BASE_ADDR) && (idx_full < ADDR_W'(DEPTH));
    assign accept   = (state_q == StIdle) && ready_q && bus.req_valid;

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    // Array is deliberately not reset; writes commit on the accept edge.
    always_ff @(posedge clk) begin
        if (accept && bus.req_wen && in_range) begin
            for (int i = 0; i < int'(NBYTES); i++) begin
                if (bus.req_wmask[i]) begin
                    mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wen_q   <= 1'b0;
            idx_q   <= '0;
            inr_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        wen_q   <= bus.req_wen;
                        idx_q   <= idx;
                        inr_q   <= in_range;
                        cnt_q   <= CNT_W'(LATENCY - 1);
                        ready_q <= 1'b0;
                        if (LATENCY > 1) begin
                            state_q <= StWait;
                        end else begin
                            state_q <= StResp;
                            valid_q <= 1'b1;
                            rdata_q <= (!bus.req_wen && in_range) ? mem[idx] : '0;
                            err_q   <= !in_range;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                StWait: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= StResp;
                        valid_q <= 1'b1;
                        rdata_q <= (!wen_q && inr_q) ? mem[idx_q] : '0;
                        err_q   <= !inr_q;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StResp: begin
                    if (bus.resp_ready) begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_npc_sim_mem.sv
// Randomised bench for npc_sim_mem: three instances (LATENCY 2, 1, 5) checked against an
// array-based reference model of the memory map.
module tb_npc_sim_mem;
    localparam int unsigned DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          sel = 0;
    logic        req_valid = 1'b0;
    logic        req_wen = 1'b0;
    logic        resp_ready = 1'b0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wmask = '0;

    logic        rdy_a [3];
    logic        val_a [3];
    logic        err_a [3];
    logic [63:0] rd_a  [3];
    logic        o_ready, o_valid, o_err;
    logic [63:0] o_rdata;

    npc_sim_mem_if #(.ADDR_W(32), .DATA_W(64)) bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 5);
        assign bus[g].req_valid  = req_valid && (sel == g);
        assign bus[g].req_wen    = req_wen;
        assign bus[g].req_addr   = req_addr;
        assign bus[g].req_wdata  = req_wdata;
        assign bus[g].req_wmask  = req_wmask;
        assign bus[g].resp_ready = resp_ready && (sel == g);
        assign rdy_a[g] = bus[g].req_ready;
        assign val_a[g] = bus[g].resp_valid;
        assign err_a[g] = bus[g].resp_err;
        assign rd_a[g]  = bus[g].resp_rdata;
        npc_sim_mem #(
            .ADDR_W(32), .DATA_W(64), .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)
        ) u_dut (
            .clk(clk),
            .reset(reset),
            .bus(bus[g])
        );
    end

    always_comb begin
        o_ready = rdy_a[sel];
        o_valid = val_a[sel];
        o_err   = err_a[sel];
        o_rdata = rd_a[sel];
    end

    // Reference model: word array per instance, address map from plain 64-bit arithmetic.
    logic [63:0] ref_mem [3][DEPTH];

    function automatic int lat_of(input int s);
        return (s == 0) ? 2 : ((s == 1) ? 1 : 5);
    endfunction

    task automatic ref_apply(input int s, input bit wen, input logic [31:0] addr,
                             input logic [63:0] wd, input logic [7:0] wm,
                             output logic [63:0] exp_rd, output bit exp_err);
        longint ua = longint'({32'h0, addr});
        longint ub = longint'({32'h0, BASE});
        int     i;
        if (ua < ub || (ua - ub) / 8 >= longint'(DEPTH)) begin
            exp_rd  = '0;
            exp_err = 1'b1;
        end else begin
            i = int'((ua - ub) / 8);
            exp_err = 1'b0;
            if (wen) begin
                for (int b = 0; b < 8; b++) if (wm[b]) ref_mem[s][i][8*b +: 8] = wd[8*b +: 8];
                exp_rd = '0;
            end else begin
                exp_rd = ref_mem[s][i];
            end
        end
    endtask

    task automatic do_req(input int s, input bit wen, input logic [31:0] addr,
                          input logic [63:0] wd, input logic [7:0] wm,
                          output logic [63:0] rd, output bit er, output int lat, output int acc);
        int n;
        sel = s;
        @(negedge clk);
        n = 0;
        while (!o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_timeout sel=%0d got %b want 1", s, o_ready);
        end
        req_wen = wen; req_addr = addr; req_wdata = wd; req_wmask = wm; req_valid = 1'b1;
        @(posedge clk);
        acc = cyc;
        #1 req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!o_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rd = o_rdata;
        er = o_err;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (rdy_a[s] !== 1'b0 || val_a[s] !== 1'b0 || rd_a[s] !== '0 || err_a[s] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs sel=%0d got rdy=%b val=%b rd=%h err=%b want 0 0 0 0",
                         s, rdy_a[s], val_a[s], rd_a[s], err_a[s]);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (rdy_a[s] !== 1'b1) begin
                errors++;
                $display("FAIL ready_after_reset sel=%0d got %b want 1", s, rdy_a[s]);
            end
        end
    endtask

    task automatic test_preload();
        logic [63:0] rd, exp_rd, wd;
        logic [31:0] a;
        bit er, exp_err;
        int lat, acc, w;
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k <= 32; k++) begin
                w  = (k == 32) ? int'(DEPTH) - 1 : k;
                a  = BASE + 32'(8 * w);
                wd = {$urandom, $urandom};
                ref_apply(s, 1'b1, a, wd, 8'hFF, exp_rd, exp_err);
                do_req(s, 1'b1, a, wd, 8'hFF, rd, er, lat, acc);
                checks++;
                if (er !== exp_err || rd !== exp_rd || lat != lat_of(s)) begin
                    errors++;
                    $display("FAIL preload sel=%0d w=%0d got err=%b rd=%h lat=%0d want %b %h %0d",
                             s, w, er, rd, lat, exp_err, exp_rd, lat_of(s));
                end
            end
        end
    endtask

    task automatic test_basic();
        logic [63:0] rd, exp_rd;
        bit er, exp_err;
        int lat, acc;
        ref_apply(0, 1'b1, 32'h8000_0010, 64'h1122334455667788, 8'hFF, exp_rd, exp_err);
        do_req(0, 1'b1, 32'h8000_0010, 64'h1122334455667788, 8'hFF, rd, er, lat, acc);
        checks++;
        if (er !== 1'b0 || rd !== '0 || lat != 2) begin
            errors++;
            $display("FAIL basic_write got err=%b rd=%h lat=%0d want 0 0 2", er, rd, lat);
        end
        do_req(0, 1'b0, 32'h8000_0010, '0, '0, rd, er, lat, acc);
        checks++;
        if (er !== 1'b0 || rd !== 64'h1122334455667788 || lat != 2) begin
            errors++;
            $display("FAIL basic_read got err=%b rd=%h lat=%0d want 0 1122334455667788 2",
                     er, rd, lat);
        end
        ref_apply(0, 1'b1, 32'h8000_0013, 64'hAAAAAAAAAAAAAAAA, 8'h0F, exp_rd, exp_err);
        do_req(0, 1'b1, 32'h8000_0013, 64'hAAAAAAAAAAAAAAAA, 8'h0F, rd, er, lat, acc);
        do_req(0, 1'b0, 32'h8000_0010, '0, '0, rd, er, lat, acc);
        checks++;
        if (er !== 1'b0 || rd !== 64'h11223344AAAAAAAA) begin
            errors++;
            $display("FAIL masked_write got err=%b rd=%h want 0 11223344aaaaaaaa", er, rd);
        end
    endtask

    task automatic test_out_of_range();
        logic [63:0] rd, exp_rd;
        bit er, exp_err;
        int lat, acc;
        do_req(0, 1'b0, 32'h7FFF_FFF8, '0, '0, rd, er, lat, acc);
        checks++;
        if (er !== 1'b1 || rd !== '0) begin
            errors++;
            $display("FAIL oor_read_below got err=%b rd=%h want 1 0", er, rd);
        end
        do_req(0, 1'b1, BASE + 32'(8 * DEPTH), 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, rd, er, lat, acc);
        checks++;
        if (er !== 1'b1 || rd !== '0 || lat != 2) begin
            errors++;
            $display("FAIL oor_write_above got err=%b rd=%h lat=%0d want 1 0 2", er, rd, lat);
        end
        ref_apply(0, 1'b0, BASE + 32'(8 * (DEPTH - 1)), '0, '0, exp_rd, exp_err);
        do_req(0, 1'b0, BASE + 32'(8 * (DEPTH - 1)), '0, '0, rd, er, lat, acc);
        checks++;
        if (er !== 1'b0 || rd !== exp_rd) begin
            errors++;
            $display("FAIL last_word got err=%b rd=%h want 0 %h", er, rd, exp_rd);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] d, exp_rd;
        bit exp_err;
        int n;
        ref_apply(0, 1'b0, 32'h8000_0010, '0, '0, exp_rd, exp_err);
        sel = 0;
        @(negedge clk);
        req_wen = 1'b0; req_addr = 32'h8000_0010; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!o_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        d = o_rdata;
        checks++;
        if (o_valid !== 1'b1 || d !== exp_rd) begin
            errors++;
            $display("FAIL bp_first_resp got val=%b rd=%h want 1 %h", o_valid, d, exp_rd);
        end
        // A competing request held during backpressure must not be taken.
        req_addr = BASE + 32'd8; req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b1 || o_rdata !== d || o_err !== 1'b0 || o_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold k=%0d got val=%b rd=%h err=%b rdy=%b want 1 %h 0 0",
                         k, o_valid, o_rdata, o_err, o_ready, d);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_after_hs got rdy=%b val=%b want 1 0", o_ready, o_valid);
        end
        ref_apply(0, 1'b0, BASE + 32'd8, '0, '0, exp_rd, exp_err);
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!o_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (o_rdata !== exp_rd || o_err !== 1'b0 || n != 2) begin
            errors++;
            $display("FAIL bp_second_resp got rd=%h err=%b lat=%0d want %h 0 2",
                     o_rdata, o_err, n, exp_rd);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd, exp_rd, wd;
        bit er, exp_err, stale;
        int lat, acc, s, n;
        for (int c = 0; c < 3; c++) begin
            s  = (c == 2) ? 0 : 2;
            wd = {$urandom, $urandom};
            sel = s;
            @(negedge clk);
            req_wen = (c == 1); req_addr = BASE + 32'd40; req_wdata = wd; req_wmask = 8'hFF;
            req_valid = 1'b1;
            if (c == 1) ref_apply(s, 1'b1, BASE + 32'd40, wd, 8'hFF, exp_rd, exp_err);
            @(posedge clk);
            #1 req_valid = 1'b0;
            @(negedge clk);
            n = 0;
            while (c == 2 && !o_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            #1 reset = 1'b1;
            #1;
            checks++;
            if (o_valid !== 1'b0 || o_ready !== 1'b0 || o_rdata !== '0 || o_err !== 1'b0) begin
                errors++;
                $display("FAIL async_reset c=%0d got val=%b rdy=%b rd=%h err=%b want 0 0 0 0",
                         c, o_valid, o_ready, o_rdata, o_err);
            end
            @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            checks++;
            if (o_ready !== 1'b1) begin
                errors++;
                $display("FAIL ready_post_reset c=%0d got %b want 1", c, o_ready);
            end
            stale = 1'b0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (o_valid !== 1'b0) stale = 1'b1;
            end
            checks++;
            if (stale) begin
                errors++;
                $display("FAIL stale_resp c=%0d got valid=1 want 0", c);
            end
        end
        ref_apply(2, 1'b0, BASE + 32'd40, '0, '0, exp_rd, exp_err);
        do_req(2, 1'b0, BASE + 32'd40, '0, '0, rd, er, lat, acc);
        checks++;
        if (rd !== exp_rd || er !== 1'b0) begin
            errors++;
            $display("FAIL write_survives_reset got rd=%h err=%b want %h 0", rd, er, exp_rd);
        end
    endtask

    task automatic test_random();
        logic [63:0] rd, exp_rd, wd;
        logic [31:0] a;
        logic [7:0]  wm;
        bit er, exp_err, wen;
        int lat, acc, r;
        for (int s = 0; s < 3; s++) begin
            for (int t = 0; t < 40; t++) begin
                wen = 1'($urandom_range(0, 1));
                r   = int'($urandom_range(0, 9));
                case (r)
                    0:       a = BASE - 32'(8 * $urandom_range(1, 100));
                    1:       a = BASE + 32'(8 * DEPTH) + 32'(8 * $urandom_range(0, 100));
                    2:       a = 32'hFFFF_FFF8;
                    3:       a = BASE + 32'(8 * (DEPTH - 1));
                    default: a = BASE + 32'(8 * $urandom_range(0, 31));
                endcase
                a[2:0] = 3'($urandom_range(0, 7));
                wd = {$urandom, $urandom};
                wm = 8'($urandom_range(0, 255));
                ref_apply(s, wen, a, wd, wm, exp_rd, exp_err);
                do_req(s, wen, a, wd, wm, rd, er, lat, acc);
                checks++;
                if (rd !== exp_rd || er !== exp_err || lat != lat_of(s)) begin
                    errors++;
                    $display("FAIL random sel=%0d t=%0d wen=%b a=%h got rd=%h err=%b lat=%0d want %h %b %0d",
                             s, t, wen, a, rd, er, lat, exp_rd, exp_err, lat_of(s));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] rd, exp_rd;
        bit er, exp_err;
        int lat, acc, prev;
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 4; k++) begin
                ref_apply(s, 1'b0, BASE + 32'(8 * k), '0, '0, exp_rd, exp_err);
                do_req(s, 1'b0, BASE + 32'(8 * k), '0, '0, rd, er, lat, acc);
                checks++;
                if (rd !== exp_rd || lat != lat_of(s) || (k > 0 && acc - prev != lat_of(s) + 1)) begin
                    errors++;
                    $display("FAIL back_to_back sel=%0d k=%0d got rd=%h lat=%0d gap=%0d want %h %0d %0d",
                             s, k, rd, lat, acc - prev, exp_rd, lat_of(s), lat_of(s) + 1);
                end
                prev = acc;
            end
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_basic();
        test_out_of_range();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
